fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  IF stage + IF/ID pipeline register. Upstream of decode; obeys stallF/stallD/flushD from hazard_unit.
//  Holds the PC, issues one imem request at a time over a valid/ready handshake, and buffers the response.
//  Delivers instrD/pcD/pcplus4D to decode and redirects on pc_targetD when decode resolves a taken branch/jump.
// PARAMETERS
//  XLEN      32            address/data width
//  RESET_PC  32'h0000_0000 PC after reset
// PORTS
//  clk             in   1     single clock, rising edge
//  reset           in   1     synchronous, active-high
//  stallF          in   1     hold PC, suppress new request
//  stallD          in   1     hold IF/ID register
//  flushD          in   1     taken branch/jump/jalr in D; redirect to pc_targetD
//  pc_targetD      in   XLEN  redirect target
//  imem_req_valid  out  1     request valid
//  imem_req_ready  in   1     request accepted when valid&ready
//  imem_req_addr   out  XLEN  = pcF
//  imem_rsp_valid  in   1     response valid (1-cycle pulse, >=1 cycle after accept, in order)
//  imem_rsp_data   in   32    instruction word
//  pcF             out  XLEN  current fetch PC
//  instrD          out  32    IF/ID instruction (NOP 32'h0000_0013 when bubble)
//  pcD, pcplus4D   out  XLEN  IF/ID PC and PC+4
//  validD          out  1     IF/ID holds a real instruction
// BEHAVIOUR
//  Reset (reset=1 at edge): pcF=RESET_PC, state=REQ, instrD=NOP, pcD=pcplus4D=0, validD=0, buf empty.
//  imem_req_valid=0 while reset high; afterwards it depends only on state/stallF (combinational).
//  redirect = flushD & ~stallD.  Priority: reset > redirect > stallD/stallF hold > normal progress.
//  FSM states:
//   REQ : imem_req_valid = ~stallF. valid&ready -> WAIT (-> DROP if redirect same cycle).
//   WAIT: on rsp_valid & ~stallD -> load IF/ID {rsp,pcF,pcF+4,1}, pcF+=4 -> REQ.
//         on rsp_valid & stallD -> capture into buf -> HOLD.
//         no rsp & ~stallD -> IF/ID loads bubble.
//   HOLD: ~stallD -> load IF/ID from buf, pcF+=4 -> REQ; stallD -> stay, IF/ID and buf unchanged.
//   DROP: wrong-path request outstanding; rsp_valid -> discard -> REQ. IF/ID loads bubble when ~stallD.
//  Redirect (any state): pcF<=pc_targetD; IF/ID<=bubble; buf discarded.
//   WAIT without rsp -> DROP.  WAIT with rsp same cycle -> discard rsp -> REQ.
//   HOLD -> REQ.  REQ with handshake -> DROP.  REQ without handshake -> REQ.
//  flushD & stallD: no redirect, no clear; everything holds (the jump stays in D until released).
//  Latency: rsp arriving in cycle N with no stall -> validD=1 in cycle N+1. Peak throughput 1 instr / 2 cycles.
//  pcplus4D = pcD + 4, modulo 2^XLEN (wraps at all-ones). pc_targetD bit0 is forced to 0 before loading pcF.
//  Exactly one request outstanding; no new request is issued in WAIT/HOLD/DROP.
//  IF/ID holds whenever stallD=1 and no reset is present.
// STRUCTURE
//  rv_pkg: NOP_INSTR=32'h0000_0013, typedef enum logic[1:0] {REQ,WAIT,HOLD,DROP} fetch_state_t,
//          typedef struct packed {instr,pc,pcplus4,valid} ifid_t.
//  Sub-module if_id_reg (ld, clr, ifid_t d/q, sync reset to bubble). FSM, PC, and buf live in fetch_stage.
// TESTING
//  1 Reset, ready=1, rsp 1 cyc after accept, no stalls -> addrs 0,4,8; validD pulses with pcD=0,4,8, pcplus4D=4,8,C.
//  2 stallD=stallF=1 for 3 cycles while rsp arrives -> HOLD; instrD unchanged; on release instrD=buf word, pcF+=4.
//  3 flushD=1, pc_targetD=0x100 while WAIT -> DROP, late rsp discarded, next req addr=0x100, validD=0 meanwhile.
//  4 flushD coincident with rsp_valid in WAIT -> rsp dropped, IF/ID bubble, next req 0x100, same cycle return to REQ.
//  5 flushD=1 & stallD=1 -> no redirect, no clear; drop stallD next cycle -> redirect occurs then.
//  6 pcF=0xFFFF_FFFC fetch -> pcplus4D=0; reset asserted in WAIT -> pcF=RESET_PC, validD=0, req_valid low.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared fetch-side types.
//   NOP_INSTR     : addi x0,x0,0, loaded into IF/ID for every bubble
//   fetch_state_t : fetch request/response sequencing states
//   ifid_t        : IF/ID pipeline register contents
package rv_pkg;

  localparam int IFID_XLEN = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {REQ, WAIT, HOLD, DROP} fetch_state_t;

  typedef struct packed {
    logic [31:0]          instr;
    logic [IFID_XLEN-1:0] pc;
    logic [IFID_XLEN-1:0] pcplus4;
    logic                 valid;
  } ifid_t;

  function automatic ifid_t ifidBubble();
    return '{instr: NOP_INSTR, pc: '0, pcplus4: '0, valid: 1'b0};
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register.
//   clk   : rising-edge clock
//   reset : synchronous active-high, loads a bubble
//   ld    : load d (ignored while clr/reset)
//   clr   : load a bubble (redirect)
//   d / q : next / current IF/ID contents
module if_id_reg
  import rv_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  ld,
  input  logic  clr,
  input  ifid_t d,
  output ifid_t q
);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      q <= ifidBubble();
    end else if (ld) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage plus IF/ID register.
// Holds the fetch PC, issues one imem request at a time, buffers a response
// that arrives while decode is stalled, and redirects on a resolved branch.
//   clk, reset                 : clock, synchronous active-high reset
//   stallF, stallD, flushD     : hazard controls
//   pc_targetD                 : redirect target (bit 0 ignored)
//   imem_req_valid/ready/addr  : request handshake, addr = pcF
//   imem_rsp_valid/data        : in-order single-cycle response pulse
//   pcF                        : current fetch PC
//   instrD, pcD, pcplus4D, validD : IF/ID outputs to decode
//
// state | meaning
// ------+---------------------------------------------------------------
// REQ   | no request outstanding; request pcF unless stallF
// WAIT  | request for pcF outstanding, response still to come
// HOLD  | response captured in bufInstr, waiting for decode to release
// DROP  | outstanding request is wrong-path; its response is discarded
module fetch_stage
  import rv_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stallF,
  input  logic            stallD,
  input  logic            flushD,
  input  logic [XLEN-1:0] pc_targetD,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic [XLEN-1:0] pcF,
  output logic [31:0]     instrD,
  output logic [XLEN-1:0] pcD,
  output logic [XLEN-1:0] pcplus4D,
  output logic            validD
);

  fetch_state_t    state;
  logic [31:0]     bufInstr;
  logic [XLEN-1:0] pcPlus4F;
  logic            redirect;
  logic            reqFire;
  logic            deliver;
  logic [31:0]     deliverInstr;
  ifid_t           ifidD;
  ifid_t           ifidQ;

  assign pcPlus4F       = pcF + XLEN'(4);
  // A flush held by a decode stall must not redirect: the jump stays in D.
  assign redirect       = flushD & ~stallD;
  assign imem_req_valid = ~reset & (state == REQ) & ~stallF;
  assign imem_req_addr  = pcF;
  assign reqFire        = imem_req_valid & imem_req_ready;

  // A real instruction enters IF/ID either straight off the response bus or
  // from the stall buffer; every other unstalled cycle loads a bubble.
  always_comb begin
    deliver      = 1'b0;
    deliverInstr = imem_rsp_data;
    case (state)
      WAIT: deliver = imem_rsp_valid & ~stallD;
      HOLD: begin
        deliver      = ~stallD;
        deliverInstr = bufInstr;
      end
      default: ;
    endcase
    ifidD = deliver ? '{instr: deliverInstr, pc: pcF, pcplus4: pcPlus4F, valid: 1'b1}
                    : ifidBubble();
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= REQ;
      pcF      <= RESET_PC;
      bufInstr <= NOP_INSTR;
    end else if (redirect) begin
      pcF <= pc_targetD & ~XLEN'(1);
      // A request already in flight (or accepted right now) is wrong-path.
      case (state)
        REQ:     state <= reqFire ? DROP : REQ;
        WAIT:    state <= imem_rsp_valid ? REQ : DROP;
        HOLD:    state <= REQ;
        DROP:    state <= imem_rsp_valid ? REQ : DROP;
        default: state <= REQ;
      endcase
    end else begin
      case (state)
        REQ: if (reqFire) state <= WAIT;
        WAIT: begin
          if (imem_rsp_valid) begin
            if (stallD) begin
              bufInstr <= imem_rsp_data;
              state    <= HOLD;
            end else begin
              state <= REQ;
            end
          end
        end
        HOLD:    if (!stallD) state <= REQ;
        DROP:    if (imem_rsp_valid) state <= REQ;
        default: state <= REQ;
      endcase
      if (deliver) pcF <= pcPlus4F;
    end
  end

  if_id_reg u_ifid (
    .clk   (clk),
    .reset (reset),
    .ld    (~stallD),
    .clr   (redirect),
    .d     (ifidD),
    .q     (ifidQ)
  );

  assign instrD   = ifidQ.instr;
  assign pcD      = ifidQ.pc;
  assign pcplus4D = ifidQ.pcplus4;
  assign validD   = ifidQ.valid;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stallF;
  logic        stallD;
  logic        flushD;
  logic [31:0] pc_targetD;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic [31:0] pcF;
  logic [31:0] instrD;
  logic [31:0] pcD;
  logic [31:0] pcplus4D;
  logic        validD;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk            (clk),
    .reset          (reset),
    .stallF         (stallF),
    .stallD         (stallD),
    .flushD         (flushD),
    .pc_targetD     (pc_targetD),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .pcF            (pcF),
    .instrD         (instrD),
    .pcD            (pcD),
    .pcplus4D       (pcplus4D),
    .validD         (validD)
  );

  localparam logic [31:0] NOP = 32'h0000_0013;

  int checks   = 0;
  int failures = 0;

  // Behavioural model: a fetch PC, one in-flight request (possibly wrong-path),
  // a single held response slot, and the expected IF/ID contents.
  logic [31:0] mPc = 32'h0;
  bit          mOut, mWrong, mHeld;
  logic [31:0] mHeldWord;
  logic [31:0] eInstr, ePc, ePc4;
  bit          eValid;
  bit          modelInit = 1'b0;
  int          rspDelay  = 1;
  int          rspTimer  = 0;
  logic [31:0] rspAddr;
  logic [31:0] accLog[$];
  logic [31:0] delPc[$];
  logic [31:0] delInstr[$];

  function automatic logic [31:0] instrAt(input logic [31:0] a);
    return {a[23:0], 8'h13} ^ 32'h0A00_0000;
  endfunction

  function automatic bit expReqValid();
    return !reset && !mOut && !mHeld && !stallF;
  endfunction

  function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return 32'hDEAD_BEEF;
  endfunction

  task automatic setBubble();
    eInstr = NOP; ePc = 32'h0; ePc4 = 32'h0; eValid = 1'b0;
  endtask

  task automatic modelStep();
    bit acc, redir, rspHere;
    acc     = expReqValid() && imem_req_ready;
    redir   = flushD && !stallD;
    rspHere = mOut && imem_rsp_valid;
    if (reset) begin
      mPc = 32'h0; mOut = 0; mWrong = 0; mHeld = 0; rspTimer = 0;
      setBubble();
      accLog.delete(); delPc.delete(); delInstr.delete();
      modelInit = 1'b1;
    end else begin
      if (acc) begin
        accLog.push_back(mPc);
        rspAddr  = mPc;
        rspTimer = rspDelay;
        mOut     = 1;
      end
      if (rspHere) begin
        mOut = 0;
        if (mWrong || redir) mWrong = 0;
        else begin mHeld = 1; mHeldWord = imem_rsp_data; end
      end
      if (redir) begin
        if (mOut) mWrong = 1;
        mHeld = 0;
        mPc   = pc_targetD & ~32'h1;
        setBubble();
      end else if (!stallD) begin
        if (mHeld) begin
          eInstr = mHeldWord; ePc = mPc; ePc4 = mPc + 32'd4; eValid = 1'b1;
          delPc.push_back(mPc); delInstr.push_back(mHeldWord);
          mPc   = mPc + 32'd4;
          mHeld = 0;
        end else begin
          setBubble();
        end
      end
    end
  endtask

  // Model update plus memory responder (fixed per-request latency).
  always @(posedge clk) begin
    modelStep();
    #1;
    if (rspTimer == 1) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = instrAt(rspAddr);
      rspTimer       = 0;
    end else begin
      imem_rsp_valid = 1'b0;
      if (rspTimer > 1) rspTimer = rspTimer - 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at t=%0t actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  task automatic compareModel();
    if (!modelInit) return;
    check("req_valid", 32'(imem_req_valid), 32'(expReqValid()));
    if (expReqValid()) check("req_addr", imem_req_addr, mPc);
    check("pcF", pcF, mPc);
    check("instrD", instrD, eInstr);
    check("pcD", pcD, ePc);
    check("pcplus4D", pcplus4D, ePc4);
    check("validD", 32'(validD), 32'(eValid));
  endtask

  // Each call finishes one cycle: compare at the falling edge, return 1 time
  // unit after the next rising edge so the caller drives the new cycle.
  task automatic tick();
    @(negedge clk);
    compareModel();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reset = 1'b1; stallF = 0; stallD = 0; flushD = 0; imem_req_ready = 1;
    pc_targetD = 32'h0;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    // 1: back-to-back fetch, no stalls
    rspDelay = 1;
    doReset();
    #1;
    check("t1 reset pcF", pcF, 32'h0);
    check("t1 reset instrD", instrD, NOP);
    check("t1 reset validD", 32'(validD), 32'h0);
    tick(); tick();
    #1;
    check("t1 validD", 32'(validD), 32'h1);
    check("t1 pcD", pcD, 32'h0);
    check("t1 pcplus4D", pcplus4D, 32'h4);
    check("t1 instrD", instrD, 32'h0A00_0013);
    repeat (6) tick();
    check("t1 acc0", qget(accLog, 0), 32'h0);
    check("t1 acc1", qget(accLog, 1), 32'h4);
    check("t1 acc2", qget(accLog, 2), 32'h8);
    check("t1 del1", qget(delPc, 1), 32'h4);
    check("t1 del2", qget(delPc, 2), 32'h8);

    // 2: stall while the response arrives
    rspDelay = 1;
    doReset();
    tick();
    stallD = 1; stallF = 1;
    tick(); tick();
    #1;
    check("t2 stall instrD", instrD, NOP);
    check("t2 stall req_valid", 32'(imem_req_valid), 32'h0);
    tick();
    stallD = 0; stallF = 0;
    #1;
    check("t2 release pcF", pcF, 32'h0);
    check("t2 release req_valid", 32'(imem_req_valid), 32'h0);
    tick();
    #1;
    check("t2 validD", 32'(validD), 32'h1);
    check("t2 instrD", instrD, 32'h0A00_0013);
    check("t2 pcF", pcF, 32'h4);
    check("t2 req_addr", imem_req_addr, 32'h4);
    repeat (4) tick();
    check("t2 del1", qget(delPc, 1), 32'h4);

    // 3: redirect while waiting, late response dropped
    rspDelay = 3;
    doReset();
    tick();
    flushD = 1; pc_targetD = 32'h100;
    tick();
    flushD = 0;
    #1;
    check("t3 pcF", pcF, 32'h100);
    check("t3 drop req_valid", 32'(imem_req_valid), 32'h0);
    check("t3 validD", 32'(validD), 32'h0);
    tick(); tick();
    #1;
    check("t3 req_valid", 32'(imem_req_valid), 32'h1);
    check("t3 req_addr", imem_req_addr, 32'h100);
    repeat (6) tick();
    check("t3 acc1", qget(accLog, 1), 32'h100);
    check("t3 del0", qget(delPc, 0), 32'h100);
    check("t3 delInstr0", qget(delInstr, 0), 32'h0A01_0013);
    check("t3 del count", 32'(delPc.size()), 32'h1);

    // 4: redirect coincident with the response
    rspDelay = 1;
    doReset();
    tick();
    flushD = 1; pc_targetD = 32'h100;
    tick();
    flushD = 0;
    #1;
    check("t4 pcF", pcF, 32'h100);
    check("t4 validD", 32'(validD), 32'h0);
    check("t4 req_valid", 32'(imem_req_valid), 32'h1);
    check("t4 req_addr", imem_req_addr, 32'h100);
    repeat (4) tick();
    check("t4 del0", qget(delPc, 0), 32'h100);
    check("t4 delInstr0", qget(delInstr, 0), 32'h0A01_0013);

    // 5: flush held by stallD, redirect once released
    rspDelay = 1;
    doReset();
    tick(); tick();
    flushD = 1; stallD = 1; stallF = 1; pc_targetD = 32'h201;
    #1;
    check("t5 held pcF", pcF, 32'h4);
    check("t5 held validD", 32'(validD), 32'h1);
    check("t5 held req_valid", 32'(imem_req_valid), 32'h0);
    tick();
    stallD = 0; stallF = 0;
    #1;
    check("t5 still pcF", pcF, 32'h4);
    check("t5 still pcD", pcD, 32'h0);
    check("t5 still validD", 32'(validD), 32'h1);
    tick();
    flushD = 0;
    #1;
    check("t5 redirect pcF", pcF, 32'h200);
    check("t5 redirect validD", 32'(validD), 32'h0);
    check("t5 drop req_valid", 32'(imem_req_valid), 32'h0);
    repeat (5) tick();
    check("t5 acc2", qget(accLog, 2), 32'h200);
    check("t5 del1", qget(delPc, 1), 32'h200);

    // 6: PC wrap, then reset while a request is outstanding
    rspDelay = 2;
    doReset();
    flushD = 1; pc_targetD = 32'hFFFF_FFFC; imem_req_ready = 0;
    tick();
    flushD = 0; imem_req_ready = 1;
    #1;
    check("t6 req_addr", imem_req_addr, 32'hFFFF_FFFC);
    tick(); tick(); tick();
    #1;
    check("t6 pcD", pcD, 32'hFFFF_FFFC);
    check("t6 pcplus4D wrap", pcplus4D, 32'h0);
    check("t6 validD", 32'(validD), 32'h1);
    check("t6 pcF wrap", pcF, 32'h0);
    repeat (4) tick();
    check("t6 pre-reset pcF", pcF, 32'h4);
    check("t6 acc0", qget(accLog, 0), 32'hFFFF_FFFC);
    reset = 1;
    #1;
    check("t6 reset req_valid", 32'(imem_req_valid), 32'h0);
    tick();
    #1;
    check("t6 reset pcF", pcF, 32'h0);
    check("t6 reset validD", 32'(validD), 32'h0);
    check("t6 reset req_valid REQ", 32'(imem_req_valid), 32'h0);
    reset = 0;
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
